rob_ar_arbiter: RTL and testbench
=================================

Name: rob_ar_arbiter

Overview:
Round-robin arbiter that shares the single AR master port of the reorder buffer between NUM_REQ upstream requesters. It registers the winning request toward the ROB slave AR port and reports the winner's index for R-side routing. It also caps in-flight reads at MAX_OUTSTANDING so the ROB ID/data FIFOs (depth 16) never overflow.

Parameters:
NUM_REQ, 4, number of upstream AR requesters (2..8)
ID_WIDTH, 4, AR ID width; matches ROB arid
MAX_OUTSTANDING, 16, max accepted-but-not-completed reads; equals ROB FIFO depth

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_arid_i  in  NUM_REQ*ID_WIDTH  requester k's ID in bits [k*ID_WIDTH +: ID_WIDTH]
s_arvalid_i  in  NUM_REQ  per-requester AR valid
s_arready_o  out  NUM_REQ  per-requester AR ready, at most one bit high
m_arid_o  out  ID_WIDTH  registered ID to ROB s_arid
m_arsrc_o  out  $clog2(NUM_REQ)  registered index of the granted requester
m_arvalid_o  out  1  registered AR valid to ROB
m_arready_i  in  1  ROB AR ready
r_done_i  in  1  one-cycle pulse per completed R beat (ROB s_rvalid && s_rready)
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count
stall_cnt_o  out  16  credit-stall cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clock edge): m_arvalid_o=0, m_arid_o=0, m_arsrc_o=0, outstanding_o=0, RR pointer=0, stall_cnt_o=0, state=IDLE. s_arready_o is all-zero while rst=1. Reset mid-transfer drops m_arvalid_o at the next edge and clears all credits.
- States: IDLE (output slot empty) and HOLD (m_arvalid_o=1, waiting for m_arready_i).
- slot_free = (state==IDLE) || (state==HOLD && m_arready_i).
- credit_ok = outstanding_o < MAX_OUTSTANDING.
- Grant: combinational. Search s_arvalid_i starting at the RR pointer, increasing index, wrapping at NUM_REQ-1→0. The first set bit wins.
- s_arready_o[win]=1 only when slot_free && credit_ok && any valid. All other bits are 0. s_arready_o never depends on its own requester's valid beyond the grant search.
- Capture: a handshake on requester k is s_arvalid_i[k] && s_arready_o[k]. At the next edge: m_arid_o<=id_k, m_arsrc_o<=k, m_arvalid_o<=1, state<=HOLD, RR pointer<=(k+1) mod NUM_REQ.
- Latency: 1 cycle from requester handshake to m_arvalid_o.
- Throughput: back-to-back, 1 request/cycle, while m_arready_i=1 and credits remain.
- HOLD with m_arready_i=0: m_arid_o and m_arsrc_o stay stable and m_arvalid_o stays 1 (AXI rule). No new grant is issued.
- HOLD with m_arready_i=1 and no new capture: m_arvalid_o<=0 and state<=IDLE.
- Credits: outstanding_o increments on each requester handshake (reserved at capture) and decrements on r_done_i.
  - Increment and decrement in the same cycle: count unchanged.
  - r_done_i with count 0: ignored, count stays 0.
  - Count never exceeds MAX_OUTSTANDING.
- At count == MAX_OUTSTANDING, all s_arready_o are 0. An r_done_i in that cycle frees a credit only from the next cycle.
- The RR pointer changes only on a capture. It is unchanged during stalls, so the starvation bound is NUM_REQ grants.

Optional Feature:
Macro ROB_ARB_STATS_EN.
- Defined: stall_cnt_o increments each cycle where any s_arvalid_i bit is 1, slot_free=1 and credit_ok=0. It saturates at 16'hFFFF and clears on reset.
- Undefined: stall_cnt_o is tied to 16'h0000 and no counter register is synthesized. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 3 cycles with s_arvalid_i=4'b1111 -> all outputs 0 and s_arready_o=0. After release, first grant is requester 0.
- Round robin: s_arvalid_i=4'b1111 held, IDs 1,2,3,4, m_arready_i=1 -> m_arsrc_o sequence 0,1,2,3,0 on consecutive cycles, m_arid_o 1,2,3,4,1, one request per cycle.
- Backpressure: capture requester 2 (id=4'hA), hold m_arready_i=0 for 5 cycles -> m_arvalid_o=1, m_arid_o=4'hA, m_arsrc_o=2 stable, s_arready_o=0 throughout. m_arready_i=1 -> next grant follows in the same cycle.
- Credit limit: issue 16 requests with r_done_i=0 -> outstanding_o=16 and s_arready_o=0. One r_done_i pulse -> outstanding_o=15 next cycle, then one more grant brings it back to 16.
- Simultaneous capture and r_done_i at count 7 -> count stays 7. r_done_i at count 0 -> stays 0.
- With ROB_ARB_STATS_EN: saturate credits and hold s_arvalid_i=1 for 10 cycles -> stall_cnt_o=10. Without the macro -> stall_cnt_o=0.

Source files
------------

// File: rtl/rob_ar_arbiter.sv
// rob_ar_arbiter: round-robin arbiter that shares the ROB's single AR port
// between NUM_REQ upstream requesters. The winning request is registered
// toward the ROB. In-flight reads are capped at MAX_OUTSTANDING so the ROB
// ID/data FIFOs cannot overflow.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   s_arid_i        packed per-requester IDs, requester k at [k*ID_WIDTH +: ID_WIDTH]
//   s_arvalid_i     per-requester AR valid
//   s_arready_o     per-requester AR ready (one-hot or zero)
//   m_arid_o        registered ID toward the ROB
//   m_arsrc_o       registered index of the granted requester (R-side routing)
//   m_arvalid_o     registered AR valid toward the ROB
//   m_arready_i     ROB AR ready
//   r_done_i        one-cycle pulse per completed read; returns a credit
//   outstanding_o   current in-flight read count
//   stall_cnt_o     credit-stall cycle counter
//
// Optional feature macro: ROB_ARB_STATS_EN
//   defined   -> stall_cnt_o counts cycles with a pending request, a free
//                output slot and no credit; saturates at 16'hFFFF
//   undefined -> stall_cnt_o is tied to zero and no counter is built
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | output slot empty, m_arvalid_o = 0
// HOLD  | m_arvalid_o = 1, waiting for m_arready_i
module rob_ar_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16,
  localparam int SRC_W          = $clog2(NUM_REQ),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*ID_WIDTH-1:0] s_arid_i,
  input  logic [NUM_REQ-1:0]          s_arvalid_i,
  output logic [NUM_REQ-1:0]          s_arready_o,
  output logic [ID_WIDTH-1:0]         m_arid_o,
  output logic [SRC_W-1:0]            m_arsrc_o,
  output logic                        m_arvalid_o,
  input  logic                        m_arready_i,
  input  logic                        r_done_i,
  output logic [CNT_W-1:0]            outstanding_o,
  output logic [15:0]                 stall_cnt_o
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] m_arid_q, m_arid_d;
  logic [SRC_W-1:0]    m_arsrc_q, m_arsrc_d;
  logic                m_arvalid_q, m_arvalid_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [ID_WIDTH-1:0] id_arr [NUM_REQ];
  logic                slot_free, credit_ok, any_valid, grant_en;
  logic                found;
  logic [SRC_W:0]      cand;
  logic [SRC_W-1:0]    win;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_id_unpack
    assign id_arr[g] = s_arid_i[g*ID_WIDTH +: ID_WIDTH];
  end

  assign slot_free = (state_q == IDLE) || m_arready_i;
  assign credit_ok = cnt_q < CNT_W'(MAX_OUTSTANDING);
  assign any_valid = |s_arvalid_i;
  // A grant is always a handshake: the winner's valid is set by construction.
  assign grant_en  = !rst && slot_free && credit_ok && any_valid;

  // Search from the RR pointer upward, wrapping at NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (SRC_W+1)'(i);
      if (cand >= (SRC_W+1)'(NUM_REQ)) begin
        cand = cand - (SRC_W+1)'(NUM_REQ);
      end
      if (!found && s_arvalid_i[cand[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    s_arready_o = '0;
    if (grant_en) begin
      s_arready_o[win] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    m_arid_d    = m_arid_q;
    m_arsrc_d   = m_arsrc_q;
    m_arvalid_d = m_arvalid_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;

    if (grant_en) begin
      state_d     = HOLD;
      m_arid_d    = id_arr[win];
      m_arsrc_d   = win;
      m_arvalid_d = 1'b1;
      ptr_d       = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (state_q == HOLD && m_arready_i) begin
      state_d     = IDLE;
      m_arvalid_d = 1'b0;
    end

    // Credit reserved at capture, returned on r_done_i; a return with
    // nothing in flight is ignored.
    if (grant_en && !(r_done_i && cnt_q != '0)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!grant_en && r_done_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_arid_q    <= '0;
      m_arsrc_q   <= '0;
      m_arvalid_q <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      m_arid_q    <= m_arid_d;
      m_arsrc_q   <= m_arsrc_d;
      m_arvalid_q <= m_arvalid_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign m_arid_o      = m_arid_q;
  assign m_arsrc_o     = m_arsrc_q;
  assign m_arvalid_o   = m_arvalid_q;
  assign outstanding_o = cnt_q;

`ifdef ROB_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (any_valid && slot_free && !credit_ok && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_rob_ar_arbiter.sv
module tb_rob_ar_arbiter;
  localparam int N = 4;
  localparam int MAXO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_arid_i;
  logic [3:0]  s_arvalid_i;
  logic [3:0]  s_arready_o;
  logic [3:0]  m_arid_o;
  logic [1:0]  m_arsrc_o;
  logic        m_arvalid_o;
  logic        m_arready_i;
  logic        r_done_i;
  logic [4:0]  outstanding_o;
  logic [15:0] stall_cnt_o;

  rob_ar_arbiter #(.NUM_REQ(4), .ID_WIDTH(4), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rst(rst), .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i),
    .s_arready_o(s_arready_o), .m_arid_o(m_arid_o), .m_arsrc_o(m_arsrc_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .r_done_i(r_done_i),
    .outstanding_o(outstanding_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int   m_ptr, m_cnt, m_src, m_stall;
  bit   m_occ;
  int   m_id;
  int   n_grants;
  int   last_src;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack_ids(input int a, input int b, input int c, input int d);
    logic [15:0] p;
    p = {4'(d), 4'(c), 4'(b), 4'(a)};
    return p;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check the
  // combinational ready, advance the model at the rising edge, then check
  // the registered outputs at the next falling edge.
  task automatic step(input logic r, input logic [3:0] v, input logic [15:0] ids,
                      input logic mr, input logic rd);
    bit   free, cok, hs, dec;
    int   w;
    logic [3:0] exp_rdy;
    rst = r; s_arvalid_i = v; s_arid_i = ids; m_arready_i = mr; r_done_i = rd;
    #1;
    free = !m_occ || mr;
    cok  = m_cnt < MAXO;
    w    = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (w < 0 && v[k]) w = k;
    end
    hs = !r && free && cok && (w >= 0);
    exp_rdy = hs ? (4'b0001 << w) : 4'b0000;
    check("s_arready", s_arready_o, exp_rdy);
    @(posedge clk);
    if (r) begin
      m_occ = 0; m_id = 0; m_src = 0; m_cnt = 0; m_ptr = 0; m_stall = 0;
    end else begin
`ifdef ROB_ARB_STATS_EN
      if (v != 0 && free && !cok && m_stall < 65535) m_stall++;
`endif
      dec = rd && (m_cnt > 0);
      m_cnt = m_cnt + (hs ? 1 : 0) - (dec ? 1 : 0);
      if (hs) begin
        m_occ = 1; m_id = (ids >> (4 * w)) & 4'hF; m_src = w; m_ptr = (w + 1) % N;
        n_grants++;
      end else if (m_occ && mr) begin
        m_occ = 0;
      end
    end
    @(negedge clk);
    check("m_arvalid", m_arvalid_o, m_occ);
    if (m_occ || r) begin
      check("m_arid", m_arid_o, m_id);
      check("m_arsrc", m_arsrc_o, m_src);
    end
    check("outstanding", outstanding_o, m_cnt);
    check("stall_cnt", stall_cnt_o, m_stall);
  endtask

  initial begin
    logic [15:0] ids1234;
    int exp_stall10;
    m_ptr = 0; m_cnt = 0; m_src = 0; m_stall = 0; m_occ = 0; m_id = 0; n_grants = 0;
    rst = 1'b1; s_arvalid_i = '0; s_arid_i = '0; m_arready_i = 1'b0; r_done_i = 1'b0;
    ids1234 = pack_ids(1, 2, 3, 4);
    @(negedge clk);

    // reset with all requesters valid
    repeat (3) step(1'b1, 4'b1111, ids1234, 1'b1, 1'b0);
    check("rst_arvalid", m_arvalid_o, 1'b0);
    check("rst_out", outstanding_o, 0);

    // round robin: sources 0,1,2,3,0 with ids 1,2,3,4,1
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, ids1234, 1'b1, 1'b0);
      check("rr_src", m_arsrc_o, i % 4);
      check("rr_id", m_arid_o, (i % 4) + 1);
    end
    check("rr_out5", outstanding_o, 5);

    // backpressure on a captured request from requester 2
    step(1'b1, 4'b0000, ids1234, 1'b1, 1'b0);
    step(1'b0, 4'b0100, pack_ids(1, 2, 4'hA, 4), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, pack_ids(1, 2, 4'hA, 4), 1'b0, 1'b0);
      check("bp_id", m_arid_o, 4'hA);
      check("bp_src", m_arsrc_o, 2);
    end
    // release: next grant in the same cycle goes to requester 3
    step(1'b0, 4'b1111, pack_ids(1, 2, 4'hA, 4), 1'b1, 1'b0);
    check("bp_next_src", m_arsrc_o, 3);

    // credit limit and stall counter
    step(1'b1, 4'b0000, ids1234, 1'b1, 1'b0);
    repeat (16) step(1'b0, 4'b0001, ids1234, 1'b1, 1'b0);
    check("cl_out16", outstanding_o, 16);
    repeat (10) step(1'b0, 4'b0001, ids1234, 1'b1, 1'b0);
`ifdef ROB_ARB_STATS_EN
    exp_stall10 = 10;
`else
    exp_stall10 = 0;
`endif
    check("stall10", stall_cnt_o, exp_stall10);
    step(1'b0, 4'b0001, ids1234, 1'b1, 1'b1);
    check("cl_out15", outstanding_o, 15);
    step(1'b0, 4'b0001, ids1234, 1'b1, 1'b0);
    check("cl_back16", outstanding_o, 16);

    // simultaneous capture and completion at count 7; completion at count 0
    step(1'b1, 4'b0000, ids1234, 1'b1, 1'b0);
    step(1'b0, 4'b0000, ids1234, 1'b1, 1'b1);
    check("done_at0", outstanding_o, 0);
    repeat (7) step(1'b0, 4'b1010, ids1234, 1'b1, 1'b0);
    check("cnt7", outstanding_o, 7);
    step(1'b0, 4'b1010, ids1234, 1'b1, 1'b1);
    check("cnt7_same", outstanding_o, 7);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), 4'($urandom), 16'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
